// File: rtl/timer_counter_pkg.sv
// Shared constants for the timer: register offsets, CTRL field positions,
// mode encodings and the FSM state type.
package timer_counter_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
endpackage

// File: rtl/timer_counter_if.sv
// System-bridge side of the timer: word-addressed register bus plus the IRQ line.
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter timer with one-shot / auto-reload modes and a
// maskable interrupt flag, accessed through three word registers.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state;

  logic wr_ctrl, wr_preset, reload;
  assign wr_ctrl   = bus.WE && (bus.Addr == ADDR_CTRL);
  assign wr_preset = bus.WE && (bus.Addr == ADDR_PRESET);
  assign reload    = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      if (wr_preset) preset <= bus.Din;
      // A CPU CTRL write overrides the one-shot Enable clear in INT.
      if (wr_ctrl) ctrl <= bus.Din[3:0];
      else if (state == INT && !reload) ctrl[CTRL_EN] <= 1'b0;
      // Any CTRL/PRESET write acknowledges; a same-cycle expiry still sets it below.
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;

      case (state)
        IDLE: if (ctrl[CTRL_EN]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[CTRL_EN]) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (reload) irq_flag <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      ADDR_CTRL:   bus.Dout = {28'd0, ctrl};
      ADDR_PRESET: bus.Dout = preset;
      ADDR_COUNT:  bus.Dout = count;
      default:     bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq_flag & ctrl[CTRL_IM];
endmodule
